// File: rtl/trig_param_bank.sv
// rtl/trig_param_bank.sv - triggered, staged parameter register bank with commit; optional readback via TRIG_PARAM_READBACK_EN
module trig_param_bank #(
  parameter int               NCH            = 16,
  parameter int               W              = 32,
  parameter logic [NCH*W-1:0] DEFAULTS       = '0,
  parameter logic [NCH-1:0]   IMMEDIATE_MASK = '0,
  parameter logic [NCH-1:0]   HOLD_MASK      = '0,
  parameter int               SELW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               sim_clk,
  input  logic               reset_global,
  input  logic [NCH-1:0]     trig_in,
  input  logic               commit_in,
  input  logic [W-1:0]       data_in,
  output logic [NCH*W-1:0]   params_out,
  output logic [NCH-1:0]     pending,
  output logic               commit_ack,
  output logic [15:0]        update_cnt,
  input  logic [SELW-1:0]    rd_sel,
  output logic [W-1:0]       rd_data
);

  localparam logic [NCH-1:0] STAGED_MASK = ~IMMEDIATE_MASK;

  logic [NCH*W-1:0] active_vec;
  logic [NCH*W-1:0] staged_vec;
  logic [NCH-1:0]   pending_vec;
  logic             commit_eff;

  // A commit is effective if a staged channel is pending or is being triggered in the same cycle
  assign commit_eff = commit_in & (|((pending_vec | trig_in) & STAGED_MASK));

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_ch
    // Declaration values give the FPGA power-up state, which HOLD channels rely on
    logic [W-1:0] active_q = DEFAULTS[gi*W +: W];
    logic [W-1:0] staged_q = DEFAULTS[gi*W +: W];
    logic         pending_q = 1'b0;
    logic [W-1:0] active_d;
    logic [W-1:0] staged_d;
    logic         pending_d;

    // Channel next state: trigger loads, commit (or immediate mode) promotes to active
    always_comb begin
      active_d  = active_q;
      staged_d  = staged_q;
      pending_d = pending_q;
      if (trig_in[gi]) begin
        staged_d = data_in;
        if (IMMEDIATE_MASK[gi] || commit_in) begin
          active_d  = data_in;
          pending_d = 1'b0;
        end else begin
          pending_d = 1'b1;
        end
      end else if (commit_in && pending_q) begin
        active_d  = staged_q;
        pending_d = 1'b0;
      end
    end

    if (HOLD_MASK[gi]) begin : g_hold
      // Held channel keeps its value and any staged entry across reset_global
      always_ff @(posedge sim_clk) begin
        active_q  <= active_d;
        staged_q  <= staged_d;
        pending_q <= pending_d;
      end
    end else begin : g_rst
      // Ordinary channel returns to its default and drops staged entries on reset
      always_ff @(posedge sim_clk or posedge reset_global) begin
        if (reset_global) begin
          active_q  <= DEFAULTS[gi*W +: W];
          staged_q  <= DEFAULTS[gi*W +: W];
          pending_q <= 1'b0;
        end else begin
          active_q  <= active_d;
          staged_q  <= staged_d;
          pending_q <= pending_d;
        end
      end
    end

    assign active_vec[gi*W +: W] = active_q;
    assign staged_vec[gi*W +: W] = staged_q;
    assign pending_vec[gi]       = pending_q;
  end

  assign params_out = active_vec;
  assign pending    = pending_vec;

  // Commit acknowledge pulse and effective-commit counter (wraps naturally)
  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      commit_ack <= 1'b0;
      update_cnt <= 16'd0;
    end else begin
      commit_ack <= commit_eff;
      if (commit_eff) begin
        update_cnt <= update_cnt + 16'd1;
      end
    end
  end

`ifdef TRIG_PARAM_READBACK_EN
  // Readback shows the staged word while pending so the host can verify before committing
  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      rd_data <= '0;
    end else if (32'(rd_sel) < NCH) begin
      rd_data <= pending_vec[rd_sel] ? staged_vec[rd_sel*W +: W] : active_vec[rd_sel*W +: W];
    end else begin
      rd_data <= '0;
    end
  end
`else
  logic unused_readback;
  assign unused_readback = ^{rd_sel, staged_vec};
  assign rd_data = '0;
`endif

endmodule

// File: tb/tb_trig_param_bank.sv
// tb/tb_trig_param_bank.sv - self-checking bench for trig_param_bank against a behavioural model
module tb_trig_param_bank;
  localparam int NCH = 8;
  localparam int W   = 32;
  localparam logic [NCH*W-1:0] DEF = {32'h0000_1007, 32'h0000_1006, 32'h0000_1005, 32'h0000_1004,
                                     32'h0000_1003, 32'h0000_1002, 32'h3CF5_C28F, 32'h3F8C_CCCD};
  localparam logic [NCH-1:0] IMM  = 8'h04;
  localparam logic [NCH-1:0] HOLD = 8'h80;

  logic             sim_clk = 1'b0;
  logic             reset_global = 1'b1;
  logic [NCH-1:0]   trig_in = '0;
  logic             commit_in = 1'b0;
  logic [W-1:0]     data_in = '0;
  logic [NCH*W-1:0] params_out;
  logic [NCH-1:0]   pending;
  logic             commit_ack;
  logic [15:0]      update_cnt;
  logic [2:0]       rd_sel = '0;
  logic [W-1:0]     rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_active [NCH];
  logic [W-1:0] m_staged [NCH];
  bit           m_pend   [NCH];
  logic [15:0]  m_cnt;
  logic         m_ack;
  logic [W-1:0] m_rd;

  trig_param_bank #(
    .NCH(NCH), .W(W), .DEFAULTS(DEF), .IMMEDIATE_MASK(IMM), .HOLD_MASK(HOLD)
  ) dut (
    .sim_clk(sim_clk), .reset_global(reset_global), .trig_in(trig_in), .commit_in(commit_in),
    .data_in(data_in), .params_out(params_out), .pending(pending), .commit_ack(commit_ack),
    .update_cnt(update_cnt), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  always #5 sim_clk = ~sim_clk;

  task automatic chk(input string tag, input logic [NCH*W-1:0] obs, input logic [NCH*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*W-1:0] pack_active();
    logic [NCH*W-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*W +: W] = m_active[i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] pack_pend();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".params"}, params_out, pack_active());
    chk({tag, ".pending"}, {{(NCH*W-NCH){1'b0}}, pending}, {{(NCH*W-NCH){1'b0}}, pack_pend()});
    chk({tag, ".ack"}, {{(NCH*W-1){1'b0}}, commit_ack}, {{(NCH*W-1){1'b0}}, m_ack});
    chk({tag, ".cnt"}, {{(NCH*W-16){1'b0}}, update_cnt}, {{(NCH*W-16){1'b0}}, m_cnt});
    chk({tag, ".rd"}, {{(NCH*W-W){1'b0}}, rd_data}, {{(NCH*W-W){1'b0}}, m_rd});
  endtask

  task automatic model_reset(input bit power_up);
    for (int i = 0; i < NCH; i++) begin
      if (power_up || !HOLD[i]) begin
        m_active[i] = DEF[i*W +: W];
        m_staged[i] = DEF[i*W +: W];
        m_pend[i]   = 1'b0;
      end
    end
    m_cnt = 16'd0;
    m_ack = 1'b0;
    m_rd  = '0;
  endtask

  // One clock: drive at negedge, update model at posedge from the pre-edge state, check 1 unit later
  task automatic cycle(input string tag, input logic [NCH-1:0] t, input logic c,
                       input logic [W-1:0] d, input logic [2:0] s);
    bit eff;
    @(negedge sim_clk);
    trig_in = t; commit_in = c; data_in = d; rd_sel = s;
    @(posedge sim_clk);
    eff = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (!IMM[i] && c && (m_pend[i] || t[i])) eff = 1'b1;
`ifdef TRIG_PARAM_READBACK_EN
    m_rd = m_pend[s] ? m_staged[s] : m_active[s];
`else
    m_rd = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      if (t[i]) begin
        m_staged[i] = d;
        if (IMM[i] || c) begin
          m_active[i] = d;
          m_pend[i]   = 1'b0;
        end else begin
          m_pend[i] = 1'b1;
        end
      end else if (c && m_pend[i]) begin
        m_active[i] = m_staged[i];
        m_pend[i]   = 1'b0;
      end
    end
    m_ack = eff;
    if (eff) m_cnt = m_cnt + 16'd1;
    #1;
    check_all(tag);
    trig_in = '0; commit_in = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset(input string tag);
    #2;
    reset_global = 1'b1;
    #1;
    model_reset(1'b0);
    check_all(tag);
    @(negedge sim_clk);
    reset_global = 1'b0;
  endtask

  initial begin
    model_reset(1'b1);
    #1;
    check_all("reset_init");
    @(negedge sim_clk);
    reset_global = 1'b0;

    cycle("stage_ch0", 8'h01, 1'b0, 32'h4000_0000, 3'd0);
    cycle("commit_ch0", 8'h00, 1'b1, 32'h0, 3'd0);
    cycle("after_commit", 8'h00, 1'b0, 32'h0, 3'd0);

    cycle("imm_ch2", 8'h04, 1'b0, 32'd5, 3'd2);
    cycle("imm_idle", 8'h00, 1'b0, 32'd0, 3'd2);

    cycle("stage_ch7", 8'h80, 1'b0, 32'h1F4, 3'd7);
    cycle("commit_ch7", 8'h00, 1'b1, 32'h0, 3'd7);
    cycle("stage_ch7b", 8'h80, 1'b0, 32'h77, 3'd7);
    pulse_reset("reset_hold");
    cycle("commit_ch7b", 8'h00, 1'b1, 32'h0, 3'd7);

    cycle("stage_ch3", 8'h08, 1'b0, 32'd7, 3'd3);
    cycle("trig_commit_ch3", 8'h08, 1'b1, 32'd9, 3'd3);
    cycle("empty_commit", 8'h00, 1'b1, 32'd0, 3'd3);
    cycle("multi_trig", 8'h33, 1'b0, 32'hDEAD_BEEF, 3'd4);
    cycle("multi_commit", 8'h00, 1'b1, 32'h0, 3'd5);

    cycle("stage_ch1_rb", 8'h02, 1'b0, 32'hAA, 3'd1);
    cycle("readback_ch1", 8'h00, 1'b0, 32'h0, 3'd1);
    cycle("readback_ch6", 8'h00, 1'b0, 32'h0, 3'd6);
    cycle("commit_ch1", 8'h00, 1'b1, 32'h0, 3'd1);

    for (int k = 0; k < 400; k++) begin
      logic [NCH-1:0] t;
      t = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
      cycle("random", t, ($urandom_range(0, 3) == 0), $urandom, 3'($urandom_range(0, NCH-1)));
      if ($urandom_range(0, 59) == 0) pulse_reset("random_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
